// File: rtl/crtc_pkg.sv
// crtc_pkg: shared CRTC register indices, PET power-on values, widths and vertical-state type
package crtc_pkg;
  localparam int R0_H_TOTAL     = 0;
  localparam int R1_H_DISPLAYED = 1;
  localparam int R2_H_SYNC_POS  = 2;
  localparam int R3_SYNC_WIDTH  = 3;
  localparam int R4_V_TOTAL     = 4;
  localparam int R5_V_ADJUST    = 5;
  localparam int R6_V_DISPLAYED = 6;
  localparam int R7_V_SYNC_POS  = 7;
  localparam int R9_MAX_SCAN    = 9;
  localparam int R12_START_HI   = 12;
  localparam int R13_START_LO   = 13;
  localparam int H_W  = 8;
  localparam int V_W  = 7;
  localparam int RA_W = 5;
  localparam int ADJ_W = 5;
  localparam logic [H_W-1:0]  PET_R0 = 8'h31;
  localparam logic [H_W-1:0]  PET_R1 = 8'h28;
  localparam logic [H_W-1:0]  PET_R2 = 8'h29;
  localparam logic [H_W-1:0]  PET_R3 = 8'h0F;
  localparam logic [V_W-1:0]  PET_R4 = 7'h28;
  localparam logic [ADJ_W-1:0] PET_R5 = 5'd5;
  localparam logic [V_W-1:0]  PET_R6 = 7'h19;
  localparam logic [V_W-1:0]  PET_R7 = 7'h21;
  localparam logic [RA_W-1:0] PET_R9 = 5'd7;
  typedef enum logic [0:0] {
    V_ROWS   = 1'b0,
    V_ADJUST = 1'b1
  } vstate_t;
  // a programmed width of 0 stands for the full 16 units
  function automatic logic [4:0] pulse_width(input logic [3:0] w);
    return {w == 4'd0, w};
  endfunction
endpackage

// File: rtl/crtc_sync_pulse.sv
// crtc_sync_pulse: retriggerable sync pulse of 1..16 advance units, registered output
module crtc_sync_pulse
  import crtc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       start,
  input  logic [3:0] width,
  input  logic       adv,
  output logic       pulse
);
  logic [4:0] cnt;
  // cnt holds the units still owed after the current one; a start restarts the count
  always_ff @(posedge clk)
    if (!reset_n) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (en) begin
      pulse <= start || cnt != 5'd0;
      cnt   <= start ? pulse_width(width) - {4'd0, adv} : (adv && cnt != 5'd0) ? cnt - 5'd1 : cnt;
    end
endmodule

// File: rtl/crtc_timing.sv
// crtc_timing: 6845-style CRTC raster timing; define CRTC_TIMING_VADJUST_EN to build the vertical adjust phase
module crtc_timing
  import crtc_pkg::*;
#(
  parameter int MA_WIDTH = 14
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cclk_en,
  input  logic [H_W-1:0]      r0_h_total,
  input  logic [H_W-1:0]      r1_h_displayed,
  input  logic [H_W-1:0]      r2_h_sync_pos,
  input  logic [H_W-1:0]      r3_sync_width,
  input  logic [V_W-1:0]      r4_v_total,
  input  logic [ADJ_W-1:0]    r5_v_adjust,
  input  logic [V_W-1:0]      r6_v_displayed,
  input  logic [V_W-1:0]      r7_v_sync_pos,
  input  logic [RA_W-1:0]     r9_max_scan,
  input  logic [MA_WIDTH-1:0] start_addr,
  output logic                h_sync,
  output logic                v_sync,
  output logic                de,
  output logic                frame_start,
  output logic [MA_WIDTH-1:0] ma,
  output logic [RA_W-1:0]     ra
);
  logic [H_W-1:0]      hc;
  logic [V_W-1:0]      vc;
  logic [RA_W-1:0]     ra_cnt;
  logic [MA_WIDTH-1:0] row_base;
  logic [MA_WIDTH-1:0] ma_next;
  logic                de_next;
  vstate_t             state, state_next;
  logic                line_end, row_end, last_row, frame_end;

  assign line_end = hc >= r0_h_total;
  assign row_end  = state == V_ROWS && line_end && ra_cnt >= r9_max_scan;
  assign last_row = row_end && vc >= r4_v_total;
`ifdef CRTC_TIMING_VADJUST_EN
  assign frame_end = (last_row && r5_v_adjust == '0) ||
                     (state == V_ADJUST && line_end && {1'b0, ra_cnt} + 6'd1 >= {1'b0, r5_v_adjust});
`else
  logic unused_r5;
  assign unused_r5 = ^r5_v_adjust;
  assign frame_end = last_row;
`endif

  // vertical state register
  always_ff @(posedge clk)
    if (!reset_n) state <= V_ROWS;
    else if (cclk_en) state <= state_next;

  // vertical next state: the last character row either hands over to the adjust lines or closes the frame
  always_comb begin
`ifdef CRTC_TIMING_VADJUST_EN
    state_next = frame_end ? V_ROWS : last_row ? V_ADJUST : state;
`else
    state_next = V_ROWS;
`endif
  end

  // raster counters; in the adjust phase ra counts the adjust lines and vc rests on the last row
  always_ff @(posedge clk)
    if (!reset_n) begin
      hc       <= '0;
      vc       <= '0;
      ra_cnt   <= '0;
      row_base <= '0;
    end else if (cclk_en) begin
      hc <= line_end ? '0 : hc + 8'd1;
      if (frame_end) begin
        vc       <= '0;
        ra_cnt   <= '0;
        row_base <= start_addr;
      end else if (row_end) begin
        vc       <= last_row ? vc : vc + 7'd1;
        ra_cnt   <= '0;
        row_base <= row_base + MA_WIDTH'(r1_h_displayed);
      end else if (line_end) begin
        ra_cnt <= ra_cnt + 5'd1;
      end
    end

  // outputs describing the character currently held in the counters
  always_comb begin
    de_next = hc < r1_h_displayed && vc < r6_v_displayed && state == V_ROWS;
    ma_next = row_base + MA_WIDTH'(hc);
  end

  // output register, loaded on the same enabled edge that advances the counters
  always_ff @(posedge clk)
    if (!reset_n) begin
      de          <= 1'b0;
      frame_start <= 1'b0;
      ma          <= '0;
      ra          <= '0;
    end else if (cclk_en) begin
      de          <= de_next;
      frame_start <= frame_end;
      ma          <= ma_next;
      ra          <= ra_cnt;
    end

  crtc_sync_pulse u_hsync (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (cclk_en),
    .start  (hc == r2_h_sync_pos),
    .width  (r3_sync_width[3:0]),
    .adv    (1'b1),
    .pulse  (h_sync)
  );

  crtc_sync_pulse u_vsync (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (cclk_en),
    .start  (hc == '0 && ra_cnt == '0 && vc == r7_v_sync_pos && state == V_ROWS),
    .width  (r3_sync_width[7:4]),
    .adv    (line_end),
    .pulse  (v_sync)
  );
endmodule

// File: tb/tb_crtc_timing.sv
// tb_crtc_timing: randomized scoreboard bench for crtc_timing against a frame-arithmetic reference model
module tb_crtc_timing;
  typedef struct packed {
    logic        h;
    logic        v;
    logic        de;
    logic        fs;
    logic [13:0] ma;
    logic [4:0]  ra;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cclk_en = 1'b0;
  logic [7:0]  r0, r1, r2, r3;
  logic [6:0]  r4, r6, r7;
  logic [4:0]  r5, r9;
  logic [13:0] start_addr;
  logic        h_sync, v_sync, de, frame_start;
  logic [13:0] ma;
  logic [4:0]  ra;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   sb_on = 1'b0;
  logic out_valid = 1'b0;

  int          pos, abs_t, abs_l, last_h, last_v;
  logic [13:0] base;

  crtc_timing #(.MA_WIDTH(14)) dut (
    .clk(clk), .reset_n(reset_n), .cclk_en(cclk_en),
    .r0_h_total(r0), .r1_h_displayed(r1), .r2_h_sync_pos(r2), .r3_sync_width(r3),
    .r4_v_total(r4), .r5_v_adjust(r5), .r6_v_displayed(r6), .r7_v_sync_pos(r7),
    .r9_max_scan(r9), .start_addr(start_addr),
    .h_sync(h_sync), .v_sync(v_sync), .de(de), .frame_start(frame_start), .ma(ma), .ra(ra)
  );

  always #5 clk = ~clk;

  always @(posedge clk) out_valid <= reset_n && cclk_en;

  // monitor: every enabled character the DUT presents is matched against the oldest prediction
  always @(negedge clk)
    if (sb_on && out_valid) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: DUT presented a character with no prediction queued");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if ({h_sync, v_sync, de, frame_start, ma, ra} !== e) begin
          n_bad++;
          $display("FAIL sb_char t=%0t got h=%b v=%b de=%b fs=%b ma=%h ra=%0d exp h=%b v=%b de=%b fs=%b ma=%h ra=%0d",
                   $time, h_sync, v_sync, de, frame_start, ma, ra, e.h, e.v, e.de, e.fs, e.ma, e.ra);
        end
      end
    end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int frame_lines();
`ifdef CRTC_TIMING_VADJUST_EN
    return (r4 + 1) * (r9 + 1) + r5;
`else
    return (r4 + 1) * (r9 + 1);
`endif
  endfunction

  // reference: locate the character inside the frame by division, then apply the raster rules
  task automatic model_step();
    int   cpl, line, hc, rows_lines, row, rac, wh, wv;
    bit   in_adj;
    exp_t e;
    cpl        = r0 + 1;
    line       = pos / cpl;
    hc         = pos % cpl;
    rows_lines = (r4 + 1) * (r9 + 1);
    in_adj     = line >= rows_lines;
    row        = in_adj ? r4 + 1 : line / (r9 + 1);
    rac        = in_adj ? line - rows_lines : line % (r9 + 1);
    wh         = (r3[3:0] == 4'd0) ? 16 : int'(r3[3:0]);
    wv         = (r3[7:4] == 4'd0) ? 16 : int'(r3[7:4]);
    if (hc == r2) last_h = abs_t;
    if (!in_adj && hc == 0 && rac == 0 && row == r7) last_v = abs_l;
    e.h  = (abs_t - last_h) < wh;
    e.v  = (abs_l - last_v) < wv;
    e.de = hc < r1 && row < r6 && !in_adj;
    e.fs = line == frame_lines() - 1 && hc == cpl - 1;
    e.ma = 14'(int'(base) + row * r1 + hc);
    e.ra = 5'(rac);
    sbq.push_back(e);
    abs_t++;
    if (hc == cpl - 1) abs_l++;
    pos++;
    if (pos == frame_lines() * cpl) begin
      pos  = 0;
      base = start_addr;
    end
  endtask

  task automatic tick(input bit en);
    cclk_en = en;
    @(posedge clk);
    if (sb_on && reset_n && en) model_step();
    #2;
  endtask

  task automatic drain();
    cclk_en = 1'b0;
    @(posedge clk);
    #2;
    sb_on = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cclk_en = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    check("reset_outputs_zero", 32'({h_sync, v_sync, de, frame_start, ma, ra}), 32'd0);
    pos = 0; abs_t = 0; abs_l = 0; base = '0;
    last_h = -1000000; last_v = -1000000;
  endtask

  task automatic set_pet();
    r0 = 8'h31; r1 = 8'h28; r2 = 8'h29; r3 = 8'h0F;
    r4 = 7'h28; r5 = 5'd5;  r6 = 7'h19; r7 = 7'h21; r9 = 5'd7;
  endtask

  initial begin
    int fl, pet_chars;
    set_pet();
    start_addr = 14'h0000;
    repeat (3) @(posedge clk);
    #2;
    for (int s = 0; s < 10; s++) begin
      r0 = 8'($urandom_range(0, 15));
      r1 = 8'($urandom_range(0, 20));
      r2 = 8'($urandom_range(0, int'(r0) + 2));
      r3 = 8'($urandom);
      r4 = 7'($urandom_range(0, 4));
      r5 = 5'($urandom_range(0, 3));
      r6 = 7'($urandom_range(0, 6));
      r7 = 7'($urandom_range(0, 5));
      r9 = 5'($urandom_range(0, 3));
      start_addr = ($urandom_range(0, 1) == 1) ? 14'h3FF0 + 14'($urandom_range(0, 15)) : 14'($urandom);
      do_reset();
      sb_on = 1'b1;
      for (int i = 0; i < 700; i++) begin
        if ($urandom_range(0, 63) == 0) start_addr = 14'($urandom);
        tick($urandom_range(0, 3) != 0);
      end
      drain();
    end

    r0 = 8'd10; r1 = 8'd4; r2 = 8'd40; r3 = 8'h11;
    r4 = 7'd2;  r5 = 5'd0; r6 = 7'd2;  r7 = 7'd50; r9 = 5'd3;
    do_reset();
    repeat (5) tick(1'b1);
    check("pre_shrink_ma", 32'(ma), 32'd4);
    r0 = 8'd3;
    tick(1'b1);
    check("shrink_last_char_ma", 32'(ma), 32'd5);
    tick(1'b1);
    check("shrink_wrap_ma", 32'(ma), 32'd0);
    check("shrink_wrap_ra", 32'(ra), 32'd1);
    tick(1'b0);
    check("hold_ma", 32'(ma), 32'd0);
    check("hold_ra", 32'(ra), 32'd1);

    set_pet();
    start_addr = 14'h0100;
    do_reset();
    sb_on = 1'b1;
    fl = frame_lines() * 50;
    pet_chars = 2 * fl + 264 * 50 + 100;
    for (int i = 0; i < pet_chars; i++) begin
      if (i == fl + 1000) start_addr = 14'h0200;
      tick(1'b1);
    end
    drain();
    check("pet_vsync_before_reset", 32'(v_sync), 32'd1);
    do_reset();
    sb_on = 1'b1;
    for (int i = 0; i < 300; i++) tick(1'b1);
    drain();
    check("queue_empty_at_end", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
